// File: rtl/rhythm_pkg.sv
// Shared definitions for the rhythm-game playback blocks: scheduler states,
// lane count, beat-period width and the system clock rate.
package rhythm_pkg;

  localparam int CLK_HZ   = 50000000;
  localparam int LANES    = 4;
  localparam int PERIOD_W = 26;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COUNTIN = 3'd1,
    S_PLAY    = 3'd2,
    S_PAUSE   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/song_rom.sv
// Combinational song pattern lookup: beat index -> active note lanes.
// Beat i occupies PATTERN[i*LANES +: LANES]; indices past the song read as a rest.
module song_rom
  import rhythm_pkg::*;
#(
  parameter int SONG_LEN = 32,
  parameter int LANES = rhythm_pkg::LANES,
  parameter logic [SONG_LEN*LANES-1:0] PATTERN = {SONG_LEN{LANES'(1)}}
) (
  input  logic [7:0]       addr,
  output logic [LANES-1:0] lanes
);

  always_comb begin
    lanes = '0;
    if (int'(addr) < SONG_LEN) lanes = PATTERN[int'(addr)*LANES +: LANES];
  end

endmodule

// File: rtl/beat_scheduler.sv
// Song playback sequencer: programmable beat timer, three-beat count-in,
// start/pause/stop control and per-beat note lane issue.
module beat_scheduler
  import rhythm_pkg::*;
#(
  parameter int CLK_HZ = rhythm_pkg::CLK_HZ,
  parameter int SONG_LEN = 32,
  parameter int LANES = rhythm_pkg::LANES,
  parameter logic [PERIOD_W-1:0] DEF_PERIOD = PERIOD_W'(CLK_HZ / 2),
  parameter logic [SONG_LEN*LANES-1:0] PATTERN = {SONG_LEN{LANES'(1)}}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                pause,
  input  logic                stop,
  input  logic [PERIOD_W-1:0] period_in,
  output logic                note_valid,
  output logic [LANES-1:0]    note_lanes,
  output logic [7:0]          beat_idx,
  output logic [1:0]          countin,
  output logic                busy,
  output logic                song_done
);

  state_t              state, state_nxt;
  logic [PERIOD_W-1:0] period, cnt;
  logic                run, tick, last_beat, accept;
  logic [7:0]          rom_addr;
  logic [LANES-1:0]    rom_lanes;

  assign run       = (state == S_COUNTIN) || (state == S_PLAY);
  assign tick      = run && (cnt == period - 1'b1);
  assign last_beat = (int'(beat_idx) == SONG_LEN - 1);
  assign accept    = start && !stop && ((state == S_IDLE) || (state == S_DONE));
  // The lookup always targets the beat about to be emitted.
  assign rom_addr  = (state == S_PLAY) ? beat_idx + 8'd1 : 8'd0;
  assign busy      = (state == S_COUNTIN) || (state == S_PLAY) || (state == S_PAUSE);
  assign song_done = (state == S_DONE);

  song_rom #(
    .SONG_LEN(SONG_LEN),
    .LANES   (LANES),
    .PATTERN (PATTERN)
  ) u_rom (
    .addr (rom_addr),
    .lanes(rom_lanes)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (stop) begin
      state_nxt = S_IDLE;
    end else if (accept) begin
      state_nxt = S_COUNTIN;
    end else begin
      case (state)
        S_COUNTIN: if (tick && countin == 2'd1) state_nxt = S_PLAY;
        // A pause coinciding with a tick lands after that beat is emitted.
        S_PLAY: begin
          if (tick && last_beat) state_nxt = S_DONE;
          else if (pause)        state_nxt = S_PAUSE;
        end
        S_PAUSE: if (pause) state_nxt = S_PLAY;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period     <= DEF_PERIOD;
      cnt        <= '0;
      beat_idx   <= '0;
      countin    <= '0;
      note_valid <= 1'b0;
      note_lanes <= '0;
    end else begin
      note_valid <= 1'b0;
      if (stop) begin
        cnt        <= '0;
        beat_idx   <= '0;
        countin    <= '0;
        note_lanes <= '0;
      end else if (accept) begin
        period     <= (period_in < PERIOD_W'(2)) ? DEF_PERIOD : period_in;
        cnt        <= '0;
        beat_idx   <= '0;
        countin    <= 2'd3;
        note_lanes <= '0;
      end else if (run) begin
        cnt <= tick ? '0 : cnt + 1'b1;
        if (tick) begin
          if (state == S_COUNTIN) begin
            countin <= countin - 2'd1;
            if (countin == 2'd1) begin
              note_valid <= 1'b1;
              note_lanes <= rom_lanes;
              beat_idx   <= '0;
            end
          end else if (last_beat) begin
            note_lanes <= '0;
          end else begin
            note_valid <= 1'b1;
            note_lanes <= rom_lanes;
            beat_idx   <= beat_idx + 8'd1;
          end
        end
      end
    end
  end

endmodule
